axis_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one AXIS sink (normally the s_axis port of `axis_fifo_v2`) between NUM_SRC AXIS producers. Each grant lasts for a bounded burst of beats or until the granted source goes idle. The granted source is passed through to the output with zero added latency, so ready and valid flow combinationally through the mux. The block sits between the per-channel event/sample generators and the shared FIFO.

---
 rtl/axis_rr_arbiter.sv | 81 ++++++++
 tb/tb_axis_rr_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: round-robin AXIS mux with bounded bursts and zero-latency pass-through
module axis_rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int AXIS_BUS_WIDTH = 64,
  parameter int MAX_BURST = 16
) (
  input  logic                              m_axi_aclk,
  input  logic                              m_axi_areset,
  input  logic [NUM_SRC*AXIS_BUS_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]                s_axis_tvalid,
  output logic [NUM_SRC-1:0]                s_axis_tready,
  output logic [AXIS_BUS_WIDTH-1:0]         m_axis_tdata,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic [$clog2(NUM_SRC)-1:0]        m_axis_tid,
  output logic [NUM_SRC-1:0]                o_grant,
  output logic                              o_busy
);
  localparam int IW = $clog2(NUM_SRC);
  localparam int CW = $clog2(MAX_BURST + 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [IW-1:0] g, g_n, last, last_n, pick;
  logic [CW-1:0] cnt, cnt_n;
  logic found, busy, hs, rel;
  assign busy = state == GRANT;
  assign hs = m_axis_tvalid && m_axis_tready;
  assign rel = busy && (!s_axis_tvalid[g] || (hs && cnt == CW'(MAX_BURST - 1)));
  assign o_busy = busy;
  assign o_grant = busy ? NUM_SRC'(1) << g : '0;
  assign s_axis_tready = m_axis_tready ? o_grant : '0;
  assign m_axis_tvalid = busy && s_axis_tvalid[g];
  assign m_axis_tid = busy ? g : '0;
  // first valid source after last, wrapping so last itself is tried at the end (last tracks g while granted)
  always_comb begin
    pick = last;
    found = 1'b0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      logic [IW:0] idx;
      idx = {1'b0, last} + (IW+1)'(k);
      if (idx >= (IW+1)'(NUM_SRC)) idx = idx - (IW+1)'(NUM_SRC);
      if (s_axis_tvalid[idx[IW-1:0]]) begin
        pick = idx[IW-1:0];
        found = 1'b1;
      end
    end
  end
  // data mux of the granted source, zero while idle
  always_comb begin
    m_axis_tdata = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (busy && g == IW'(i)) m_axis_tdata = s_axis_tdata[i*AXIS_BUS_WIDTH +: AXIS_BUS_WIDTH];
  end
  // idle waits for any request; a release re-arbitrates in the same cycle so there is no bubble
  always_comb begin
    state_n = state;
    g_n = g;
    last_n = last;
    cnt_n = cnt;
    if (!busy || rel) begin
      state_n = found ? GRANT : IDLE;
      g_n = found ? pick : g;
      last_n = found ? pick : last;
      cnt_n = '0;
    end else if (hs) cnt_n = cnt + 1'b1;
  end
  // arbitration state, last starts at the top source so the first search begins at source 0
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      state <= IDLE;
      g <= '0;
      last <= IW'(NUM_SRC - 1);
      cnt <= '0;
    end else begin
      state <= state_n;
      g <= g_n;
      last <= last_n;
      cnt <= cnt_n;
    end
  end
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: directed and randomized checks of axis_rr_arbiter against a behavioural model
module tb_axis_rr_arbiter;
  localparam int N = 4, W = 64, MB = 16;
  logic clk = 0, rst = 1;
  logic [N*W-1:0] s_tdata;
  logic [N-1:0] s_tvalid, s_tready, o_grant;
  logic [W-1:0] m_tdata;
  logic m_tvalid, m_tready, o_busy;
  logic [1:0] m_tid;
  logic [W-1:0] sd [N];
  int seq [N], left [N], exp_seq [N];
  bit acc [N];
  int prob = 100, rmode = 0;
  int checks = 0, errors = 0;
  int m_cur = -1, m_ptr = N - 1, m_beats = 0, m_cyc = 0;
  bit m_known = 0;
  int n_busy = 0, n_hs = 0;
  int b_tid[$], b_len[$], b_cyc[$];

  always #5 clk = ~clk;
  always_comb for (int i = 0; i < N; i++) s_tdata[i*W +: W] = sd[i];

  axis_rr_arbiter #(.NUM_SRC(N), .AXIS_BUS_WIDTH(W), .MAX_BURST(MB)) dut (
    .m_axi_aclk(clk), .m_axi_areset(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tid(m_tid), .o_grant(o_grant), .o_busy(o_busy)
  );

  // model: who owns the sink, how many beats it moved, and who is searched next
  always @(negedge clk) begin
    logic [N-1:0] eg, etr;
    logic ev, eb;
    logic [W-1:0] ed;
    logic [1:0] etid;
    bit hs;
    int nxt;
    eg = '0; ev = 0; ed = '0; etid = '0; eb = 0;
    if (m_cur >= 0) begin
      eg = 4'(1) << m_cur;
      ev = s_tvalid[m_cur];
      ed = sd[m_cur];
      etid = 2'(m_cur);
      eb = 1;
    end
    etr = m_tready ? eg : '0;
    if (m_known) begin
      checks++;
      if ({o_grant, m_tvalid, m_tid, s_tready, o_busy, m_tdata} !== {eg, ev, etid, etr, eb, ed}) begin
        errors++;
        $display("FAIL outputs t=%0t grant=%b/%b tvalid=%b/%b tid=%0d/%0d tready=%b/%b busy=%b/%b tdata=%h/%h (got/exp)",
                 $time, o_grant, eg, m_tvalid, ev, m_tid, etid, s_tready, etr, o_busy, eb, m_tdata, ed);
      end
    end
    for (int i = 0; i < N; i++) acc[i] = (s_tvalid[i] && s_tready[i]) === 1'b1;
    n_busy += int'(o_busy === 1'b1);
    n_hs += int'((m_tvalid && m_tready) === 1'b1);
    hs = m_cur >= 0 && s_tvalid[m_cur] && m_tready;
    if (m_cur >= 0) m_cyc++;
    if (hs) begin
      checks++;
      if (sd[m_cur] !== {32'(m_cur), 32'(exp_seq[m_cur])}) begin
        errors++;
        $display("FAIL beat_order src=%0d got=%h exp seq=%0d", m_cur, sd[m_cur], exp_seq[m_cur]);
      end
      exp_seq[m_cur]++;
      m_beats++;
    end
    if (rst) begin
      m_known = 1;
      m_cur = -1;
      m_ptr = N - 1;
    end else if (m_cur < 0 || !s_tvalid[m_cur] || m_beats == MB) begin
      if (m_cur >= 0) begin
        b_tid.push_back(m_cur);
        b_len.push_back(m_beats);
        b_cyc.push_back(m_cyc);
      end
      nxt = -1;
      for (int j = N; j >= 1; j--) if (s_tvalid[(m_ptr + j) % N]) nxt = (m_ptr + j) % N;
      m_cur = nxt;
      if (nxt >= 0) begin
        m_ptr = nxt;
        m_beats = 0;
        m_cyc = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) seq[i]++;
      if (!s_tvalid[i] || acc[i]) begin
        s_tvalid[i] = left[i] > 0 && $urandom_range(99) < prob;
        if (s_tvalid[i]) left[i]--;
      end
      sd[i] = {32'(i), 32'(seq[i])};
    end
    m_tready = rmode == 0 ? 1'b1 : rmode == 1 ? ~m_tready : 1'($urandom_range(1));
  endtask

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic chk_burst(string name, int k, int tid, int len);
    if (k >= b_tid.size()) begin
      checks++;
      errors++;
      $display("FAIL %s burst %0d missing, got %0d bursts", name, k, b_tid.size());
    end else begin
      chk($sformatf("%s_tid%0d", name, k), 64'(b_tid[k]), 64'(tid));
      chk($sformatf("%s_len%0d", name, k), 64'(b_len[k]), 64'(len));
    end
  endtask

  task automatic drain();
    int k = 0;
    for (int i = 0; i < N; i++) left[i] = 0;
    rmode = 0;
    while ((s_tvalid != 0 || o_busy !== 1'b0) && k < 300) begin
      tick();
      k++;
    end
    if (k == 300) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout tvalid=%b busy=%b", s_tvalid, o_busy);
    end
  endtask

  task automatic do_reset(int n);
    rst = 1;
    repeat (n) tick();
    rst = 0;
    for (int i = 0; i < N; i++) begin
      seq[i] = 0;
      exp_seq[i] = 0;
    end
    b_tid.delete();
    b_len.delete();
    b_cyc.delete();
    n_busy = 0;
    n_hs = 0;
  endtask

  initial begin
    int k;
    s_tvalid = '0;
    m_tready = 1;
    for (int i = 0; i < N; i++) begin
      sd[i] = '0;
      seq[i] = 0;
      exp_seq[i] = 0;
      left[i] = 1000;
    end
    repeat (3) tick();
    chk("rst_grant", 64'(o_grant), 0);
    chk("rst_tvalid", 64'(m_tvalid), 0);
    chk("rst_tready", 64'(s_tready), 0);
    chk("rst_busy", 64'(o_busy), 0);
    rst = 0;
    tick();
    chk("rst_first_grant", 64'(o_grant), 64'b0001);
    chk("rst_first_tid", 64'(m_tid), 0);
    drain();

    do_reset(2);
    left[1] = 40;
    repeat (60) tick();
    chk_burst("single", 0, 1, 16);
    chk_burst("single", 1, 1, 16);
    chk_burst("single", 2, 1, 8);
    chk("single_beats", 64'(n_hs), 40);
    chk("single_busy_cycles", 64'(n_busy), 41);
    chk("single_idle_after", 64'(o_busy), 0);
    drain();

    do_reset(2);
    for (int i = 0; i < N; i++) left[i] = 1000;
    repeat (90) tick();
    chk_burst("sat", 0, 0, 16);
    chk_burst("sat", 1, 1, 16);
    chk_burst("sat", 2, 2, 16);
    chk_burst("sat", 3, 3, 16);
    chk_burst("sat", 4, 0, 16);
    chk("sat_bubbles", 64'(n_busy - n_hs), 0);
    drain();

    do_reset(2);
    left[0] = 1000;
    left[2] = 1000;
    rmode = 1;
    repeat (110) tick();
    chk_burst("bp", 0, 0, 16);
    chk_burst("bp", 1, 2, 16);
    chk_burst("bp", 2, 0, 16);
    if (b_cyc.size() >= 3) begin
      chk("bp_span1", 64'(b_cyc[1]), 32);
      chk("bp_span2", 64'(b_cyc[2]), 32);
    end
    drain();

    do_reset(2);
    left[2] = 5;
    left[3] = 16;
    k = 0;
    while (m_cur != 3 && k < 50) begin
      tick();
      k++;
    end
    chk("early_wait_src3", 64'(m_cur), 3);
    left[0] = 3;
    left[2] = 3;
    repeat (40) tick();
    chk_burst("early", 0, 2, 5);
    chk_burst("early", 1, 3, 16);
    chk_burst("early", 2, 0, 3);
    chk_burst("early", 3, 2, 3);
    if (b_cyc.size() >= 1) chk("early_release_cycles", 64'(b_cyc[0]), 6);
    drain();

    do_reset(2);
    left[2] = 1000;
    k = 0;
    while (!(m_cur == 2 && m_beats == 7) && k < 50) begin
      tick();
      k++;
    end
    chk("mid_wait_beat7", 64'(m_beats), 7);
    rst = 1;
    for (int i = 0; i < N; i++) left[i] = 1000;
    tick();
    rst = 0;
    chk("mid_rst_grant", 64'(o_grant), 0);
    chk("mid_rst_tvalid", 64'(m_tvalid), 0);
    chk("mid_rst_busy", 64'(o_busy), 0);
    tick();
    chk("mid_first_grant", 64'(o_grant), 64'b0001);
    drain();

    do_reset(2);
    prob = 70;
    rmode = 2;
    for (int i = 0; i < N; i++) left[i] = 100000;
    repeat (3000) tick();
    prob = 100;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
